// File: rtl/dshot_rx_decoder.sv
// -----------------------------------------------------------------------------
// dshot_rx_decoder
// Receive-side DShot decoder. Samples one DShot line on the 16 MHz system
// clock and classifies each bit by the width of its high pulse. It assembles
// 16-bit frames, MSB first, then checks the 4-bit CRC. On a good frame it
// presents the throttle and telemetry fields together with a one-cycle strobe.
//
// Ports
//   clk_in       system clock, 16 MHz
//   reset        asynchronous, active-high reset
//   enable       1 = decode; 0 = hold in SYNC, counters cleared, no strobes
//   dshot_in     raw asynchronous DShot line
//   throttle     throttle field [15:5] of the last valid frame
//   telemetry    telemetry-request bit [4] of the last valid frame
//   frame_valid  strobe: frame received, CRC good, throttle/telemetry updated
//   crc_err      strobe: 16 bits received, CRC mismatch, outputs held
//   frame_err    strobe: glitch, oversize pulse or mid-frame timeout
//
// Handshake: the three strobes are single-cycle, push-only events with no
// back-pressure. At most one is high in any cycle, and two never appear in
// consecutive cycles. throttle/telemetry are stable except in the cycle
// frame_valid is high, which is the first cycle the new values are visible.
// -----------------------------------------------------------------------------
module dshot_rx_decoder #(
  parameter int BIT_CLKS    = 27,
  parameter int THRESH_CLKS = 15,
  parameter int MIN_HIGH    = 4,
  parameter int MAX_HIGH    = 24,
  parameter int GAP_CLKS    = 54
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        enable,
  input  logic        dshot_in,
  output logic [10:0] throttle,
  output logic        telemetry,
  output logic        frame_valid,
  output logic        crc_err,
  output logic        frame_err
);

  if (!(MIN_HIGH < THRESH_CLKS && THRESH_CLKS <= MAX_HIGH &&
        MAX_HIGH < BIT_CLKS && BIT_CLKS < GAP_CLKS && GAP_CLKS < 255)) begin : g_param_check
    $error("dshot_rx_decoder: inconsistent timing parameters");
  end

  localparam logic [7:0] THRESH_L = 8'(THRESH_CLKS);
  localparam logic [7:0] MIN_L    = 8'(MIN_HIGH);
  localparam logic [7:0] MAX_L    = 8'(MAX_HIGH);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CLKS - 1);

  typedef enum logic [2:0] {
    SYNC  = 3'd0,
    IDLE  = 3'd1,
    HIGH  = 3'd2,
    LOW   = 3'd3,
    CHECK = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        sync1_q, din_s, din_d;
  logic [7:0]  cnt_q;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] shift_q, shift_d;
  logic        frame_valid_d, crc_err_d, frame_err_d;

  logic        rise, fall, low_run_done, bit_val, crc_ok;
  logic [15:0] frame_next;

  // Two-flop synchronizer plus one delayed copy for edge detection.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      din_s   <= 1'b0;
      din_d   <= 1'b0;
    end else begin
      sync1_q <= dshot_in;
      din_s   <= sync1_q;
      din_d   <= din_s;
    end
  end

  assign rise = din_s & ~din_d;
  assign fall = ~din_s & din_d;

  // cnt_q is the number of cycles din_s has spent at its previous level
  // before the current cycle. On a falling edge it is therefore exactly the
  // high width of the pulse that just ended.
  assign low_run_done = ~din_s & ~din_d & (cnt_q >= GAP_LAST);
  assign bit_val      = (cnt_q >= THRESH_L);
  assign frame_next   = {shift_q[14:0], bit_val};

  // The CRC is evaluated as the 16th bit shifts in. The registered strobe
  // and the fields then land in the single CHECK cycle, one clock after the
  // final falling edge.
  assign crc_ok = ((frame_next[15:12] ^ frame_next[11:8] ^ frame_next[7:4]) == frame_next[3:0]);

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    frame_valid_d = 1'b0;
    crc_err_d     = 1'b0;
    frame_err_d   = 1'b0;
    if (!enable) begin
      state_d   = SYNC;
      bit_cnt_d = 4'd0;
      shift_d   = 16'd0;
    end else begin
      case (state_q)
        SYNC: begin
          if (low_run_done) state_d = IDLE;
        end
        IDLE: begin
          if (rise) begin
            state_d   = HIGH;
            bit_cnt_d = 4'd0;
            shift_d   = 16'd0;
          end
        end
        HIGH: begin
          // Oversize test comes first so a pulse of MAX_HIGH+1 is rejected
          // even when it ends in this very cycle.
          if (cnt_q > MAX_L) begin
            frame_err_d = 1'b1;
            state_d     = SYNC;
          end else if (fall) begin
            if (cnt_q < MIN_L) begin
              frame_err_d = 1'b1;
              state_d     = SYNC;
            end else begin
              shift_d   = frame_next;
              bit_cnt_d = bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd15) begin
                state_d       = CHECK;
                frame_valid_d = crc_ok;
                crc_err_d     = ~crc_ok;
              end else begin
                state_d = LOW;
              end
            end
          end
        end
        LOW: begin
          if (rise) begin
            state_d = HIGH;
          end else if (low_run_done) begin
            frame_err_d = 1'b1;
            state_d     = SYNC;
          end
        end
        CHECK: begin
          state_d = SYNC;
        end
        default: begin
          state_d = SYNC;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q     <= SYNC;
      cnt_q       <= 8'd0;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 16'd0;
      throttle    <= 11'd0;
      telemetry   <= 1'b0;
      frame_valid <= 1'b0;
      crc_err     <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      frame_valid <= frame_valid_d;
      crc_err     <= crc_err_d;
      frame_err   <= frame_err_d;
      if (frame_valid_d) begin
        throttle  <= shift_d[15:5];
        telemetry <= shift_d[4];
      end
      // The edge cycle is the first cycle of the new level, so the count
      // restarts at 1. It saturates to give a stable "long" reading.
      if (!enable)
        cnt_q <= 8'd0;
      else if (din_s != din_d)
        cnt_q <= 8'd1;
      else if (cnt_q != 8'hFF)
        cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_dshot_rx_decoder.sv
// -----------------------------------------------------------------------------
// tb_dshot_rx_decoder
// Directed bench for dshot_rx_decoder. A table of frames with bit widths and
// hand-computed results covers CRC-good and CRC-bad frames and the width
// boundaries. Hand-written sequences cover reset, mid-frame timeout, glitch
// and oversize pulses, back-to-back frames and enable.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dshot_rx_decoder;

  localparam int BIT_CLKS = 27;
  localparam int GAP_CLKS = 54;
  localparam int MAX_HIGH = 24;
  localparam int K_VALID  = 0;
  localparam int K_CRC    = 1;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        dshot_in = 1'b0;
  logic [10:0] throttle;
  logic        telemetry, frame_valid, crc_err, frame_err;

  dshot_rx_decoder dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .enable      (enable),
    .dshot_in    (dshot_in),
    .throttle    (throttle),
    .telemetry   (telemetry),
    .frame_valid (frame_valid),
    .crc_err     (crc_err),
    .frame_err   (frame_err)
  );

  // ---------------- clock / cycle counter ----------------
  always #31.25 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_bad = 0;
  int fv_n, ce_n, fe_n;
  int fv_cyc, ce_cyc, fe_cyc;
  int last_fall;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_events();
    fv_n = 0; ce_n = 0; fe_n = 0;
    fv_cyc = -1; ce_cyc = -1; fe_cyc = -1;
  endtask

  // ---------------- strobe monitor ----------------
  logic        prev_any = 1'b0;
  logic [10:0] thr_prev = 11'd0;
  logic        tel_prev = 1'b0;

  always @(negedge clk_in) begin
    if (reset) begin
      prev_any = 1'b0;
      thr_prev = throttle;
      tel_prev = telemetry;
    end else begin
      if (frame_valid || crc_err || frame_err) begin
        n_vec++;
        if ((int'(frame_valid) + int'(crc_err) + int'(frame_err)) != 1 || prev_any) begin
          n_bad++;
          $display("FAIL strobe_excl: fv=%0b ce=%0b fe=%0b prev=%0b, expected one strobe after a quiet cycle",
                   frame_valid, crc_err, frame_err, prev_any);
        end
        if (frame_valid) begin fv_n++; fv_cyc = cyc; end
        if (crc_err)     begin ce_n++; ce_cyc = cyc; end
        if (frame_err)   begin fe_n++; fe_cyc = cyc; end
      end
      if (throttle !== thr_prev || telemetry !== tel_prev) begin
        n_vec++;
        if (!frame_valid) begin
          n_bad++;
          $display("FAIL field_hold: throttle %0d->%0d telemetry %0b->%0b with frame_valid=0, expected no change",
                   thr_prev, throttle, tel_prev, telemetry);
        end
      end
      prev_any = frame_valid | crc_err | frame_err;
      thr_prev = throttle;
      tel_prev = telemetry;
    end
  end

  // ---------------- driver tasks (called just after a rising edge) ----------------
  task automatic hold(input logic lvl, input int n);
    dshot_in = lvl;
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] f, input int hi_idx, input int lo_idx,
                           input int one_hi, input int zero_hi);
    int hi;
    for (int i = hi_idx; i >= lo_idx; i--) begin
      hi = f[i] ? one_hi : zero_hi;
      hold(1'b1, hi);
      last_fall = cyc;
      hold(1'b0, BIT_CLKS - hi);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] frame;
    int          one_hi;
    int          zero_hi;
    int          kind;
    logic [10:0] thr;
    logic        tel;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int t;
    vecs[0]  = '{16'h82C6, 20, 10, K_VALID, 11'd1046, 1'b0};
    vecs[1]  = '{16'h82C7, 20, 10, K_CRC,   11'd1046, 1'b0};
    vecs[2]  = '{16'h0011, 20, 10, K_VALID, 11'd0,    1'b1};
    vecs[3]  = '{16'hFFFF, 20, 10, K_VALID, 11'd2047, 1'b1};
    vecs[4]  = '{16'hA5A5, 20, 10, K_VALID, 11'd1325, 1'b0};
    vecs[5]  = '{16'hA5A4, 20, 10, K_CRC,   11'd1325, 1'b0};
    vecs[6]  = '{16'h1230, 15, 14, K_VALID, 11'd145,  1'b1};
    vecs[7]  = '{16'h0000, 15, 14, K_VALID, 11'd0,    1'b0};
    vecs[8]  = '{16'hFFFF, 15, 14, K_VALID, 11'd2047, 1'b1};
    vecs[9]  = '{16'h82C6, 24, 4,  K_VALID, 11'd1046, 1'b0};
    vecs[10] = '{16'h0011, 24, 4,  K_VALID, 11'd0,    1'b1};
    vecs[11] = '{16'h82C7, 24, 4,  K_CRC,   11'd0,    1'b1};

    // ---- reset state ----
    clear_events();
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("rst_throttle", int'(throttle), 0);
    check("rst_telemetry", int'(telemetry), 0);
    check("rst_strobes", int'({frame_valid, crc_err, frame_err}), 0);
    @(posedge clk_in); #1;
    reset = 1'b0;

    // ---- table-driven frames ----
    foreach (vecs[k]) begin
      clear_events();
      hold(1'b0, 60);
      send_bits(vecs[k].frame, 15, 0, vecs[k].one_hi, vecs[k].zero_hi);
      hold(1'b0, 10);
      check($sformatf("v%0d_fv_n", k), fv_n, (vecs[k].kind == K_VALID) ? 1 : 0);
      check($sformatf("v%0d_ce_n", k), ce_n, (vecs[k].kind == K_CRC) ? 1 : 0);
      check($sformatf("v%0d_fe_n", k), fe_n, 0);
      if (vecs[k].kind == K_VALID)
        check($sformatf("v%0d_latency", k), fv_cyc - last_fall, 3);
      else
        check($sformatf("v%0d_latency", k), ce_cyc - last_fall, 3);
      check($sformatf("v%0d_throttle", k), int'(throttle), int'(vecs[k].thr));
      check($sformatf("v%0d_telemetry", k), int'(telemetry), int'(vecs[k].tel));
    end

    // ---- mid-frame timeout, then a good frame ----
    clear_events();
    hold(1'b0, 60);
    send_bits(16'h82C6, 15, 8, 20, 10);
    hold(1'b0, 60);
    check("timeout_fe_n", fe_n, 1);
    check("timeout_fe_time", fe_cyc - last_fall, 2 + GAP_CLKS);
    check("timeout_other", fv_n + ce_n, 0);
    clear_events();
    send_bits(16'h0011, 15, 0, 20, 10);
    hold(1'b0, 10);
    check("after_to_fv_n", fv_n, 1);
    check("after_to_telemetry", int'(telemetry), 1);
    check("after_to_throttle", int'(throttle), 0);

    // ---- glitches: 2 and 3 clocks high ----
    for (int w = 2; w <= 3; w++) begin
      clear_events();
      hold(1'b0, 60);
      hold(1'b1, w);
      t = cyc;
      hold(1'b0, 20);
      check($sformatf("glitch%0d_fe_n", w), fe_n, 1);
      check($sformatf("glitch%0d_fe_time", w), fe_cyc - t, 3);
    end

    // ---- oversize pulses: 25 and 30 clocks high ----
    for (int w = 25; w <= 30; w += 5) begin
      clear_events();
      hold(1'b0, 60);
      t = cyc;
      hold(1'b1, w);
      hold(1'b0, 20);
      check($sformatf("over%0d_fe_n", w), fe_n, 1);
      check($sformatf("over%0d_fe_time", w), fe_cyc - t, 2 + (MAX_HIGH + 1) + 1);
      check($sformatf("over%0d_other", w), fv_n + ce_n, 0);
    end

    // ---- back-to-back frames: second one ignored ----
    clear_events();
    hold(1'b0, 60);
    send_bits(16'h82C6, 15, 0, 20, 10);
    send_bits(16'h0011, 15, 0, 20, 10);
    hold(1'b0, 60);
    check("b2b_fv_n", fv_n, 1);
    check("b2b_err_n", ce_n + fe_n, 0);
    check("b2b_throttle", int'(throttle), 1046);
    check("b2b_telemetry", int'(telemetry), 0);

    // ---- enable dropped mid-frame: no strobes, outputs held ----
    clear_events();
    hold(1'b0, 60);
    send_bits(16'h0011, 15, 8, 20, 10);
    enable = 1'b0;
    hold(1'b0, 3);
    enable = 1'b1;
    send_bits(16'h0011, 7, 0, 20, 10);
    hold(1'b0, 60);
    check("en_strobes", fv_n + ce_n + fe_n, 0);
    check("en_throttle", int'(throttle), 1046);

    // ---- reset mid-frame, then resync and decode ----
    clear_events();
    hold(1'b0, 60);
    send_bits(16'h0011, 15, 8, 20, 10);
    reset = 1'b1;
    @(posedge clk_in); #1;
    reset = 1'b0;
    @(negedge clk_in);
    check("midrst_throttle", int'(throttle), 0);
    check("midrst_telemetry", int'(telemetry), 0);
    @(posedge clk_in); #1;
    hold(1'b0, 60);
    send_bits(16'h82C6, 15, 0, 20, 10);
    hold(1'b0, 10);
    check("midrst_fv_n", fv_n, 1);
    check("midrst_err_n", ce_n + fe_n, 0);
    check("midrst_dec_throttle", int'(throttle), 1046);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
